// File: rtl/mtf_pkg.sv
// -----------------------------------------------------------------------------
// mtf_pkg
// Shared definitions for the MTF neuron-side blocks.
//   enc_state_t : spike encoder FSM states (BELOW / ABOVE threshold)
//   *_DEF       : default widths and buffer depth
//   sat_inc     : saturating increment for counters of any width up to 32
// -----------------------------------------------------------------------------
package mtf_pkg;

    typedef enum logic {
        BELOW = 1'b0,
        ABOVE = 1'b1
    } enc_state_t;

    localparam int unsigned V_W_DEF        = 8;
    localparam int unsigned ISI_W_DEF      = 16;
    localparam int unsigned CNT_W_DEF      = 16;
    localparam int unsigned FIFO_DEPTH_DEF = 4;

    // Returns val+1, clamped at 2^width-1. Callers truncate to their width.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/mtf_spike_encoder_fifo.sv
// -----------------------------------------------------------------------------
// spike_isi_fifo
// Synchronous show-ahead FIFO for ISI events.
//   clk, reset : clock, asynchronous active-high reset (empties the FIFO)
//   i_push     : write request, i_data written when accepted
//   i_pop      : read request, ignored while empty
//   o_data     : head entry (0 while empty)
//   o_empty    : no entries held
//   o_drop     : push requested while full with no pop; entry discarded
// A push into a full FIFO is accepted when a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module spike_isi_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_drop
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_full;
    logic             w_pop_ok;
    logic             w_push_ok;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!w_full || w_pop_ok);
    assign o_drop    = i_push && !w_push_ok;
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: the head is masked to 0 while empty.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/mtf_spike_encoder.sv
// -----------------------------------------------------------------------------
// mtf_spike_encoder
// Converts the MTF neuron membrane voltage into spike events using a
// hysteresis threshold plus refractory window, measures inter-spike intervals
// and buffers them for the gait/CPG controller.
//   clk, reset  : clock, asynchronous active-high reset
//   v_in        : membrane voltage, sampled every cycle
//   thresh      : firing threshold
//   hyst        : hysteresis; re-arm level is thresh-hyst floored at 0
//   refrac      : refractory length in cycles (0 = none)
//   spike       : one-cycle pulse, the cycle after detection
//   spike_count : spikes since reset, wrapping
//   ev_valid    : ISI event available
//   ev_ready    : consumer takes the head event
//   ev_isi      : head ISI in cycles (2^ISI_W-1 means "at least that")
//   overflow    : sticky, an ISI was dropped on a full buffer
// -----------------------------------------------------------------------------
module mtf_spike_encoder
    import mtf_pkg::*;
#(
    parameter int unsigned V_W        = V_W_DEF,
    parameter int unsigned ISI_W      = ISI_W_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [V_W-1:0]   v_in,
    input  logic [V_W-1:0]   thresh,
    input  logic [V_W-1:0]   hyst,
    input  logic [7:0]       refrac,
    output logic             spike,
    output logic [CNT_W-1:0] spike_count,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [ISI_W-1:0] ev_isi,
    output logic             overflow
);

    enc_state_t       r_state;
    enc_state_t       w_state_nxt;
    logic [V_W-1:0]   w_lo;
    logic             w_rearm;
    logic             w_detect;
    logic [7:0]       r_refrac_cnt;
    logic [ISI_W-1:0] r_isi_cnt;
    logic [ISI_W-1:0] w_isi_inc;
    logic [ISI_W-1:0] r_isi_val;
    logic             r_first_seen;
    logic             r_push_pend;
    logic             r_spike;
    logic [CNT_W-1:0] r_spike_count;
    logic             r_overflow;
    logic             w_empty;
    logic             w_drop;

    assign w_lo      = (thresh > hyst) ? (thresh - hyst) : '0;
    assign w_rearm   = (v_in < w_lo) && (r_refrac_cnt == 8'd0);
    assign w_isi_inc = ISI_W'(sat_inc(32'(r_isi_cnt), ISI_W));

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= BELOW;
        else       r_state <= w_state_nxt;
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BELOW:   if (v_in >= thresh) w_state_nxt = ABOVE;
            ABOVE:   if (w_rearm)        w_state_nxt = BELOW;
            default: w_state_nxt = BELOW;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_detect = 1'b0;
        if (r_state == BELOW) w_detect = (v_in >= thresh);
    end

    // Refractory, ISI and spike bookkeeping. The ISI is captured at detect
    // and pushed one cycle later so the push lines up with the spike pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_refrac_cnt  <= '0;
            r_isi_cnt     <= '0;
            r_isi_val     <= '0;
            r_first_seen  <= 1'b0;
            r_push_pend   <= 1'b0;
            r_spike       <= 1'b0;
            r_spike_count <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_spike <= w_detect;

            if (w_detect)
                r_refrac_cnt <= refrac;
            else if (r_state == ABOVE && r_refrac_cnt != 8'd0)
                r_refrac_cnt <= r_refrac_cnt - 8'd1;

            if (w_detect) begin
                r_isi_cnt    <= '0;
                r_isi_val    <= w_isi_inc;
                r_push_pend  <= r_first_seen;
                r_first_seen <= 1'b1;
            end else begin
                r_isi_cnt   <= w_isi_inc;
                r_push_pend <= 1'b0;
            end

            if (r_spike) r_spike_count <= r_spike_count + CNT_W'(1);
            if (w_drop)  r_overflow    <= 1'b1;
        end
    end

    spike_isi_fifo #(
        .WIDTH (ISI_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_push_pend),
        .i_data  (r_isi_val),
        .i_pop   (ev_ready),
        .o_data  (ev_isi),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );

    assign spike       = r_spike;
    assign spike_count = r_spike_count;
    assign ev_valid    = !w_empty;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_mtf_spike_encoder.sv
// -----------------------------------------------------------------------------
// tb_mtf_spike_encoder
// Directed stimulus for mtf_spike_encoder. Each step states whether a spike
// (and a dropped ISI) is expected; the expected ISI is the step distance
// between spikes, queued for a monitor that checks the event interface.
// -----------------------------------------------------------------------------
module tb_mtf_spike_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  v_in = '0;
    logic [7:0]  thresh = 8'd100;
    logic [7:0]  hyst = 8'd20;
    logic [7:0]  refrac = 8'd0;
    logic        spike;
    logic [15:0] spike_count;
    logic        ev_valid;
    logic        ev_ready = 1'b1;
    logic [15:0] ev_isi;
    logic        overflow;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;
    int unsigned m_last = 0;
    bit          m_first = 1'b0;
    bit          m_pend = 1'b0;
    bit          m_ovf = 1'b0;
    bit          m_ovf_pend = 1'b0;
    logic [15:0] m_cnt = '0;
    logic [15:0] q[$];

    mtf_spike_encoder #(
        .V_W        (8),
        .ISI_W      (16),
        .CNT_W      (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .v_in        (v_in),
        .thresh      (thresh),
        .hyst        (hyst),
        .refrac      (refrac),
        .spike       (spike),
        .spike_count (spike_count),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_isi      (ev_isi),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops on handshake, otherwise the head must hold steady.
    always @(negedge clk) begin
        if (!reset && ev_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_event", 32'(ev_isi), 32'hFFFF_FFFF);
            end else if (ev_ready) begin
                chk("ev_isi_pop", 32'(ev_isi), 32'(q.pop_front()));
            end else begin
                chk("ev_isi_hold", 32'(ev_isi), 32'(q[0]));
            end
        end
    end

    task automatic step(input logic [7:0] v, input bit exp_spk, input bit exp_drop);
        logic [31:0] isi;
        v_in = v;
        @(posedge clk);
        #1;
        cyc++;
        m_cnt = m_cnt + 16'(m_pend);
        m_ovf = m_ovf | m_ovf_pend;
        chk("spike", 32'(spike), 32'(exp_spk));
        chk("spike_count", 32'(spike_count), 32'(m_cnt));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        m_pend = exp_spk;
        m_ovf_pend = exp_drop;
        if (exp_spk) begin
            if (m_first) begin
                isi = cyc - m_last;
                if (isi > 32'd65535) isi = 32'd65535;
                if (!exp_drop) q.push_back(isi[15:0]);
            end
            m_first = 1'b1;
            m_last = cyc;
        end
    endtask

    task automatic spike_after(input int unsigned n_low, input bit exp_drop);
        repeat (n_low) step(8'd50, 1'b0, 1'b0);
        step(8'd120, 1'b1, exp_drop);
        step(8'd120, 1'b0, 1'b0);
    endtask

    // Reset is raised between clock edges so its effect is seen before any edge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        v_in = '0;
        #1;
        chk("rst_spike", 32'(spike), 32'd0);
        chk("rst_count", 32'(spike_count), 32'd0);
        chk("rst_ev_valid", 32'(ev_valid), 32'd0);
        chk("rst_ev_isi", 32'(ev_isi), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        q.delete();
        m_first = 1'b0;
        m_pend = 1'b0;
        m_ovf = 1'b0;
        m_ovf_pend = 1'b0;
        m_cnt = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();

        // Single crossing: first spike carries no ISI
        repeat (10) step(8'd0, 1'b0, 1'b0);
        step(8'd120, 1'b1, 1'b0);
        repeat (4) step(8'd120, 1'b0, 1'b0);
        chk("first_no_event", 32'(ev_valid), 32'd0);

        // Periodic 5 high / 5 low: ISI 10 each
        for (int i = 0; i < 4; i++) begin
            repeat (5) step(8'd50, 1'b0, 1'b0);
            step(8'd120, 1'b1, 1'b0);
            repeat (4) step(8'd120, 1'b0, 1'b0);
        end

        // Hysteresis: dip to 90 stays above lo=80, no re-arm
        refrac = 8'd8;
        repeat (5) step(8'd50, 1'b0, 1'b0);
        step(8'd120, 1'b1, 1'b0);
        repeat (12) step(8'd90, 1'b0, 1'b0);
        repeat (3) step(8'd120, 1'b0, 1'b0);
        step(8'd50, 1'b0, 1'b0);
        step(8'd120, 1'b1, 1'b0);
        // Refractory: low through detect+8 only, back high at +9 -> no spike
        repeat (2) step(8'd90, 1'b0, 1'b0);
        repeat (6) step(8'd70, 1'b0, 1'b0);
        repeat (4) step(8'd120, 1'b0, 1'b0);
        step(8'd70, 1'b0, 1'b0);
        step(8'd120, 1'b1, 1'b0);
        // Low through detect+9 re-arms; detect at +10 gives ISI 10
        repeat (2) step(8'd90, 1'b0, 1'b0);
        repeat (7) step(8'd70, 1'b0, 1'b0);
        step(8'd120, 1'b1, 1'b0);
        // hyst > thresh: lo floors at 0, never re-arms
        hyst = 8'd150;
        repeat (2) step(8'd120, 1'b0, 1'b0);
        repeat (12) step(8'd0, 1'b0, 1'b0);
        repeat (2) step(8'd120, 1'b0, 1'b0);
        hyst = 8'd20;
        refrac = 8'd0;
        step(8'd50, 1'b0, 1'b0);
        step(8'd120, 1'b1, 1'b0);
        repeat (3) step(8'd120, 1'b0, 1'b0);
        chk("drained_valid", 32'(ev_valid), 32'd0);
        chk("drained_sb", 32'(q.size()), 32'd0);

        // Backpressure: ISIs 4,5,6,7 fill the buffer
        do_reset();
        ev_ready = 1'b0;
        spike_after(2, 1'b0);
        spike_after(2, 1'b0);
        spike_after(3, 1'b0);
        spike_after(4, 1'b0);
        spike_after(5, 1'b0);
        chk("full_valid", 32'(ev_valid), 32'd1);
        chk("full_head", 32'(ev_isi), 32'd4);
        // Full, push of ISI 8 together with a pop: nothing dropped
        repeat (6) step(8'd50, 1'b0, 1'b0);
        step(8'd120, 1'b1, 1'b0);
        ev_ready = 1'b1;
        step(8'd120, 1'b0, 1'b0);
        ev_ready = 1'b0;
        chk("pushpop_head", 32'(ev_isi), 32'd5);
        // Full, push of ISI 9 without a pop: dropped, overflow set
        repeat (7) step(8'd50, 1'b0, 1'b0);
        step(8'd120, 1'b1, 1'b1);
        step(8'd120, 1'b0, 1'b0);
        // Drain: exactly four entries 5,6,7,8
        ev_ready = 1'b1;
        repeat (3) step(8'd50, 1'b0, 1'b0);
        chk("drain_valid_3", 32'(ev_valid), 32'd1);
        step(8'd50, 1'b0, 1'b0);
        chk("drain_valid_4", 32'(ev_valid), 32'd0);
        chk("drain_sb", 32'(q.size()), 32'd0);

        // Saturation: 70002-cycle interval clamps to 65535
        step(8'd120, 1'b1, 1'b0);
        step(8'd50, 1'b0, 1'b0);
        v_in = 8'd50;
        repeat (70000) @(posedge clk);
        #1;
        cyc += 70000;
        chk("quiet_spike", 32'(spike), 32'd0);
        ev_ready = 1'b0;
        step(8'd120, 1'b1, 1'b0);
        repeat (2) step(8'd120, 1'b0, 1'b0);
        chk("sat_valid", 32'(ev_valid), 32'd1);
        chk("sat_isi", 32'(ev_isi), 32'd65535);

        // Asynchronous reset mid-ABOVE, then next spike is a first spike
        do_reset();
        ev_ready = 1'b1;
        repeat (2) step(8'd50, 1'b0, 1'b0);
        step(8'd120, 1'b1, 1'b0);
        repeat (3) step(8'd120, 1'b0, 1'b0);
        chk("post_rst_no_event", 32'(ev_valid), 32'd0);
        chk("post_rst_sb", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
